// File: rtl/fsm_fetch_dispatch_pkg.sv
// Shared control-unit definitions: opcode values, one-hot code bit positions,
// execution-unit indices and the fetch/dispatch state encoding.
package fsm_fetch_dispatch_pkg;

  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpImm32   = 7'b0011011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpLoadFp  = 7'b0000111;
  localparam logic [6:0] OpStoreFp = 7'b0100111;
  localparam logic [6:0] OpFp      = 7'b1010011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;

  localparam int unsigned CodeOp      = 0;
  localparam int unsigned CodeOp32    = 1;
  localparam int unsigned CodeImm     = 2;
  localparam int unsigned CodeImm32   = 3;
  localparam int unsigned CodeLoad    = 4;
  localparam int unsigned CodeStore   = 5;
  localparam int unsigned CodeLui     = 6;
  localparam int unsigned CodeAuipc   = 7;
  localparam int unsigned CodeLoadFp  = 8;
  localparam int unsigned CodeStoreFp = 9;
  localparam int unsigned CodeFp      = 10;
  localparam int unsigned CodeBranch  = 24;
  localparam int unsigned CodeJal     = 25;
  localparam int unsigned CodeJalr    = 26;

  localparam int unsigned NumUnits = 4;

  typedef enum logic [1:0] {
    UnitAlu    = 2'd0,
    UnitBranch = 2'd1,
    UnitLsu    = 2'd2,
    UnitFpu    = 2'd3
  } unit_e;

  typedef enum logic [2:0] {
    StFetch    = 3'd0,
    StDecode   = 3'd1,
    StDispatch = 3'd2,
    StWaitDone = 3'd3,
    StTrap     = 3'd4
  } state_e;

  // Watchdog value seen on the last WAIT_DONE cycle; it reaches 255 on the trap edge.
  localparam logic [7:0] WdogLast = 8'd254;

  function automatic logic [NumUnits-1:0] unit_onehot(input unit_e unit);
    return 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/opcode_onehot_dec.sv
// Combinational opcode classifier: 7-bit major opcode to one-hot class code,
// legality flag and target execution unit.
module opcode_onehot_dec
  import fsm_fetch_dispatch_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output logic [31:0] code_o,
  output logic        valid_o,
  output unit_e       unit_o
);

  always_comb begin
    code_o  = '0;
    valid_o = 1'b1;
    unit_o  = UnitAlu;
    unique case (opcode_i)
      OpOp:      code_o[CodeOp]    = 1'b1;
      OpOp32:    code_o[CodeOp32]  = 1'b1;
      OpImm:     code_o[CodeImm]   = 1'b1;
      OpImm32:   code_o[CodeImm32] = 1'b1;
      OpLui:     code_o[CodeLui]   = 1'b1;
      OpAuipc:   code_o[CodeAuipc] = 1'b1;
      OpLoad: begin
        code_o[CodeLoad] = 1'b1;
        unit_o           = UnitLsu;
      end
      OpStore: begin
        code_o[CodeStore] = 1'b1;
        unit_o            = UnitLsu;
      end
      OpLoadFp: begin
        code_o[CodeLoadFp] = 1'b1;
        unit_o             = UnitLsu;
      end
      OpStoreFp: begin
        code_o[CodeStoreFp] = 1'b1;
        unit_o              = UnitLsu;
      end
      OpFp: begin
        code_o[CodeFp] = 1'b1;
        unit_o         = UnitFpu;
      end
      OpBranch: begin
        code_o[CodeBranch] = 1'b1;
        unit_o             = UnitBranch;
      end
      OpJal: begin
        code_o[CodeJal] = 1'b1;
        unit_o          = UnitBranch;
      end
      OpJalr: begin
        code_o[CodeJalr] = 1'b1;
        unit_o           = UnitBranch;
      end
      default: valid_o = 1'b0;
    endcase
    // Compressed encodings are never legal here, whatever the upper bits say.
    if (opcode_i[1:0] != 2'b11) begin
      code_o  = '0;
      valid_o = 1'b0;
      unit_o  = UnitAlu;
    end
  end

endmodule

// File: rtl/fsm_fetch_dispatch.sv
// Fetch/decode/dispatch control FSM: fetches one instruction, classifies it,
// starts one execution FSM and waits for its completion under a watchdog.
module fsm_fetch_dispatch
  import fsm_fetch_dispatch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  input  logic [NumUnits-1:0] done,
  output logic                mem_req,
  output logic [31:0]         ins,
  output logic [31:0]         code,
  output logic [NumUnits-1:0] start,
  output logic                illegal,
  output logic                timeout,
  output logic [63:0]         instret
);

  state_e      state_q, state_d;
  logic [31:0] ins_q, code_q;
  unit_e       sel_q;
  logic        illegal_q, timeout_q, mem_req_q;
  logic [63:0] instret_q;
  logic [7:0]  wdog_q;

  logic [31:0] dec_code;
  logic        dec_valid;
  unit_e       dec_unit;
  logic        sel_done;

  opcode_onehot_dec u_dec (
    .opcode_i (ins_q[6:0]),
    .code_o   (dec_code),
    .valid_o  (dec_valid),
    .unit_o   (dec_unit)
  );

  assign sel_done = done[sel_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ack) state_d = StDecode;
      StDecode:   state_d = dec_valid ? StDispatch : StTrap;
      StDispatch: state_d = StWaitDone;
      StWaitDone: begin
        if (sel_done) begin
          state_d = StFetch;
        end else if (wdog_q == WdogLast) begin
          state_d = StTrap;
        end
      end
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    start = '0;
    if (state_q == StDispatch) begin
      start = unit_onehot(sel_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_q <= 1'b0;
      ins_q     <= '0;
      code_q    <= '0;
      sel_q     <= UnitAlu;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
      wdog_q    <= '0;
    end else begin
      // Request rises one cycle into FETCH and drops on the ack edge.
      mem_req_q <= (state_q == StFetch) && (state_d == StFetch);
      if (state_q == StFetch && mem_ack) begin
        ins_q <= mem_rdata;
      end
      if (state_q == StDecode) begin
        code_q <= dec_code;
        sel_q  <= dec_unit;
        if (!dec_valid) begin
          illegal_q <= 1'b1;
        end
      end
      if (state_q == StDispatch) begin
        wdog_q <= '0;
      end else if (state_q == StWaitDone) begin
        wdog_q <= wdog_q + 8'd1;
      end
      if (state_q == StWaitDone && state_d == StTrap) begin
        timeout_q <= 1'b1;
      end
      if (state_q == StWaitDone && sel_done) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign mem_req = mem_req_q;
  assign ins     = ins_q;
  assign code    = code_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;

endmodule

// File: doc/fsm_fetch_dispatch.md
FSM_FETCH_DISPATCH -- requirements
Module: fsm_fetch_dispatch

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port mem_rdata, input, 32: instruction word from instruction memory.
REQ-004 SHALL have port mem_ack, input, 1: mem_rdata is valid this cycle.
REQ-005 SHALL have port done, input, 4: one-hot completion pulse from each execution FSM (0 int-ALU, 1 branch/jump, 2 load/store, 3 float).
REQ-006 SHALL have port mem_req, output, 1: fetch request, level.
REQ-007 SHALL have port ins, output, 32: latched instruction register.
REQ-008 SHALL have port code, output, 32: registered one-hot opcode class.
REQ-009 SHALL have port start, output, 4: one-cycle dispatch pulse, same indexing as done.
REQ-010 SHALL have port illegal, output, 1: sticky illegal-opcode flag.
REQ-011 SHALL have port timeout, output, 1: sticky watchdog flag.
REQ-012 SHALL have port instret, output, 64: retired-instruction count.

Function
REQ-013 SHALL implement states FETCH, DECODE, DISPATCH, WAIT_DONE, TRAP.
REQ-014 FETCH SHALL drive mem_req=1 until mem_ack=1; on that edge it SHALL latch ins<=mem_rdata and go to DECODE; mem_ack outside FETCH SHALL be ignored.
REQ-015 DECODE SHALL register code from ins[6:0]: 0110011->bit0, 0111011->1, 0010011->2, 0011011->3, 0000011->4, 0100011->5, 0110111->6, 0010111->7, 0000111->8, 0100111->9, 1010011->10, 1100011->24, 1101111->25, 1100111->26; all other bits 0.
REQ-016 DECODE SHALL go to TRAP, setting illegal=1 and code=0, when ins[6:0] matches no listed opcode or ins[1:0]!=2'b11; otherwise it SHALL go to DISPATCH.
REQ-017 DISPATCH SHALL assert exactly one start bit for one cycle: bit0 for code bits 0-3,6,7; bit1 for 24-26; bit2 for 4,5,8,9; bit3 for 10. Next state SHALL be WAIT_DONE.
REQ-018 ins and code SHALL hold stable from DECODE exit until the next FETCH latch.
REQ-019 WAIT_DONE SHALL return to FETCH on the cycle after done[sel]=1 (sel = dispatched index) and increment instret by 1 on that edge; done bits other than sel SHALL be ignored.
REQ-020 A done[sel] pulse in the same cycle as start SHALL be ignored; only done seen in WAIT_DONE counts.
REQ-021 WAIT_DONE SHALL run an 8-bit watchdog cleared on entry; when it reaches 255 with no done[sel], go to TRAP and set timeout=1.
REQ-022 TRAP SHALL be absorbing: mem_req=0, start=0, and only rst_n=0 exits it.
REQ-023 instret SHALL wrap from 2^64-1 to 0.
REQ-024 Minimum instruction cadence SHALL be: ack edge -> DECODE -> DISPATCH (start) -> WAIT_DONE -> FETCH, i.e. mem_req re-asserts 2 cycles after the done edge seen in WAIT_DONE.

Reset
REQ-025 On rst_n=0 at a clk edge: state=FETCH, mem_req=0 for that cycle, ins=0, code=0, start=0, illegal=0, timeout=0, instret=0, watchdog=0.
REQ-026 Reset asserted mid-operation (any state, including a pending fetch or WAIT_DONE) SHALL abandon the operation with no instret increment; first mem_req SHALL be the cycle after rst_n returns 1.

Structure
REQ-027 Opcode localparams, code bit indices, start indices and state encoding SHALL live in a shared control-unit package used by all FSMs.
REQ-028 Opcode-to-one-hot mapping SHALL be a combinational sub-module opcode_onehot_dec (ins[6:0] -> code, valid, start index).

Verification
REQ-029 Fetch 0x003100B3 (add) with ack after 3 wait cycles -> code=0x00000001, start=4'b0001 for one cycle; done[0] -> instret=1, mem_req re-asserts.
REQ-030 Fetch 0x00208463 (beq) -> code[24]=1, start=4'b0010; done[1] after 4 cycles -> instret increments; a stray done[0] in WAIT_DONE is ignored.
REQ-031 Fetch 0x008000EF (jal) -> code=0x02000000, start[1] pulse; ins stays 0x008000EF until next ack.
REQ-032 Fetch 0xFFFFFFFF -> illegal=1, code=0, no start pulse, mem_req stays 0 until reset.
REQ-033 Dispatch then withhold done -> timeout=1 after 255 WAIT_DONE cycles; pulsing rst_n=0 mid-WAIT_DONE clears all outputs, instret stays 0.
